// File: rtl/apb_reg_slave.sv
// APB4 completer exposing NUM_REGS read/write registers with wait states, byte strobes and decode errors.
// Optional APB_REG_LOCK_EN: the top register's bit0 write-protects all other registers.
module apb_reg_slave #(
  parameter int                        APB_ADDR_WIDTH = 16,
  parameter int                        APB_DATA_WIDTH = 32,
  parameter int                        NUM_REGS       = 16,
  parameter int                        WAIT_STATES    = 0,
  parameter logic [APB_DATA_WIDTH-1:0] RESET_VALUE    = '0
) (
  input  logic                               PCLK,
  input  logic                               PRESETn,
  input  logic [APB_ADDR_WIDTH-1:0]          PADDR,
  input  logic                               PWRITE,
  input  logic [APB_DATA_WIDTH-1:0]          PWDATA,
  input  logic [APB_DATA_WIDTH/8-1:0]        PSTRB,
  input  logic                               PSEL,
  input  logic                               PENABLE,
  output logic                               PREADY,
  output logic [APB_DATA_WIDTH-1:0]          PRDATA,
  output logic                               PSLVERR,
  output logic [NUM_REGS*APB_DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]                reg_wr
);
  localparam int BW   = APB_DATA_WIDTH / 8;
  localparam int OFFW = $clog2(BW);
  localparam int IW   = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
  localparam logic [APB_ADDR_WIDTH-1:0] ADDR_MASK = APB_ADDR_WIDTH'(BW - 1);
  localparam logic [APB_ADDR_WIDTH:0]   NR_L      = (APB_ADDR_WIDTH + 1)'(NUM_REGS);
  localparam logic [3:0]                WS        = 4'(WAIT_STATES);

  typedef enum logic {IDLE, ACCESS} state_e;

  state_e                                   state_q, state_d;
  logic [3:0]                               cnt_q, cnt_d;
  logic [NUM_REGS-1:0][APB_DATA_WIDTH-1:0]  regs_q, regs_d;
  logic [NUM_REGS-1:0]                      reg_wr_q, reg_wr_d;

  logic [APB_ADDR_WIDTH-1:0] idx_full;
  logic [IW-1:0]             idx;
  logic                      misalign, range_err, lock_err, err, wr_en, rd_en;

  assign idx_full  = PADDR >> OFFW;
  assign idx       = idx_full[IW-1:0];
  assign misalign  = |(PADDR & ADDR_MASK);
  assign range_err = {1'b0, idx_full} >= NR_L;

`ifdef APB_REG_LOCK_EN
  localparam logic [IW-1:0] LOCK_IDX = IW'(NUM_REGS - 1);
  // Lock register itself stays writable so software can always unlock.
  assign lock_err = PWRITE && regs_q[NUM_REGS-1][0] && (idx != LOCK_IDX);
`else
  assign lock_err = 1'b0;
`endif

  assign err     = misalign | range_err | lock_err;
  assign PREADY  = (state_q == ACCESS) && PSEL && PENABLE && (cnt_q == WS);
  assign PSLVERR = PREADY && err;
  assign wr_en   = PREADY && PWRITE && !err;
  assign rd_en   = PREADY && !PWRITE && !err;
  assign PRDATA  = rd_en ? regs_q[idx] : '0;
  assign reg_q   = regs_q;
  assign reg_wr  = reg_wr_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (PSEL && !PENABLE) begin
          state_d = ACCESS;
          cnt_d   = '0;
        end
      end
      ACCESS: begin
        if (!PSEL || PREADY) state_d = IDLE;  // PSEL drop before PREADY aborts
        else if (PENABLE && (cnt_q < WS)) cnt_d = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    regs_d   = regs_q;
    reg_wr_d = '0;
    if (wr_en) begin
      reg_wr_d[idx] = 1'b1;
      for (int b = 0; b < BW; b++)
        if (PSTRB[b]) regs_d[idx][b*8 +: 8] = PWDATA[b*8 +: 8];
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      reg_wr_q <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VALUE;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      reg_wr_q <= reg_wr_d;
      regs_q   <= regs_d;
    end
  end
endmodule

// File: tb/tb_apb_reg_slave.sv
// Scoreboard bench: two completers (zero-wait and 3-wait) driven by randomized and directed APB transfers.
module tb_apb_reg_slave;
  localparam int AW = 16, DW = 32, NR = 16;
  localparam logic [31:0] RV0 = 32'h0000_0000, RV3 = 32'h0000_1234;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    logic [15:0] wmask;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst_n   [2];
  logic [AW-1:0]  paddr   [2];
  logic           pwrite  [2];
  logic [31:0]    pwdata  [2];
  logic [3:0]     pstrb   [2];
  logic           psel    [2];
  logic           penable [2];
  logic           pready  [2];
  logic [31:0]    prdata  [2];
  logic           pslverr [2];
  logic [NR*DW-1:0] regq  [2];
  logic [NR-1:0]  regwr   [2];

  logic [31:0] model [2][NR];
  logic [15:0] expwr [2];
  int          wsv   [2];
  exp_t        q0[$], q1[$];
  int          checks = 0, errors = 0;

  apb_reg_slave #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
                  .WAIT_STATES(0), .RESET_VALUE(RV0)) dut0 (
    .PCLK(clk), .PRESETn(rst_n[0]), .PADDR(paddr[0]), .PWRITE(pwrite[0]),
    .PWDATA(pwdata[0]), .PSTRB(pstrb[0]), .PSEL(psel[0]), .PENABLE(penable[0]),
    .PREADY(pready[0]), .PRDATA(prdata[0]), .PSLVERR(pslverr[0]),
    .reg_q(regq[0]), .reg_wr(regwr[0]));

  apb_reg_slave #(.APB_ADDR_WIDTH(AW), .APB_DATA_WIDTH(DW), .NUM_REGS(NR),
                  .WAIT_STATES(3), .RESET_VALUE(RV3)) dut3 (
    .PCLK(clk), .PRESETn(rst_n[1]), .PADDR(paddr[1]), .PWRITE(pwrite[1]),
    .PWDATA(pwdata[1]), .PSTRB(pstrb[1]), .PSEL(psel[1]), .PENABLE(penable[1]),
    .PREADY(pready[1]), .PRDATA(prdata[1]), .PSLVERR(pslverr[1]),
    .reg_q(regq[1]), .reg_wr(regwr[1]));

  // Monitor: reg_wr must equal the pulse implied by the transfer that completed one cycle earlier.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst_n[d] === 1'b1) begin
        checks++;
        if (regwr[d] !== expwr[d]) begin
          errors++;
          $display("FAIL reg_wr dut%0d got %h exp %h", d, regwr[d], expwr[d]);
        end
        expwr[d] = '0;
        if (pready[d] === 1'b1) begin
          exp_t e;
          bit   have;
          have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
          checks++;
          if (!have) begin
            errors++;
            $display("FAIL unexpected_ready dut%0d got PREADY=1 exp no pending transfer", d);
          end else begin
            e = (d == 0) ? q0.pop_front() : q1.pop_front();
            if (prdata[d] !== e.rdata || pslverr[d] !== e.err) begin
              errors++;
              $display("FAIL resp dut%0d got rdata=%h err=%b exp rdata=%h err=%b",
                       d, prdata[d], pslverr[d], e.rdata, e.err);
            end
            expwr[d] = e.wmask;
          end
        end
      end else expwr[d] = '0;
    end
  end

  function automatic logic exp_err(input int d, input logic [15:0] a, input logic w);
    int  idx;
    logic e;
    logic [1:0] lo;
    idx = int'(a >> 2);
    lo  = a[1:0];
    e   = (lo != 2'b00) || (idx >= NR);
`ifdef APB_REG_LOCK_EN
    if (!e && w && idx != NR-1 && model[d][NR-1][0]) e = 1'b1;
`endif
    return e;
  endfunction

  task automatic xfer(input int d, input logic [15:0] a, input logic w,
                      input logic [31:0] data, input logic [3:0] strb);
    exp_t e;
    int   idx, n;
    idx     = int'(a >> 2);
    e.err   = exp_err(d, a, w);
    e.rdata = '0;
    e.wmask = '0;
    if (!e.err) begin
      if (w) begin
        e.wmask = 16'(1 << idx);
        for (int b = 0; b < 4; b++)
          if (strb[b]) model[d][idx][b*8 +: 8] = data[b*8 +: 8];
      end else e.rdata = model[d][idx];
    end
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(posedge clk); #1;
    paddr[d] = a; pwrite[d] = w; pwdata[d] = data; pstrb[d] = strb;
    psel[d] = 1'b1; penable[d] = 1'b0;
    @(posedge clk); #1;
    penable[d] = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pready[d] !== 1'b1 && n < 40);
    checks++;
    if (pready[d] !== 1'b1 || n != wsv[d] + 1) begin
      errors++;
      $display("FAIL latency dut%0d got %0d access cycles exp %0d", d, n, wsv[d] + 1);
    end
    @(posedge clk); #1;
    psel[d] = 1'b0; penable[d] = 1'b0;
  endtask

  task automatic check_regq(input int d);
    for (int i = 0; i < NR; i++) begin
      checks++;
      if (regq[d][i*DW +: DW] !== model[d][i]) begin
        errors++;
        $display("FAIL reg_q dut%0d reg%0d got %h exp %h", d, i, regq[d][i*DW +: DW], model[d][i]);
      end
    end
  endtask

  initial begin
    wsv[0] = 0; wsv[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0; psel[d] = 1'b0; penable[d] = 1'b0; pwrite[d] = 1'b0;
      paddr[d] = '0; pwdata[d] = '0; pstrb[d] = '0; expwr[d] = '0;
      for (int i = 0; i < NR; i++) model[d][i] = (d == 0) ? RV0 : RV3;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checks++;
      if (pready[d] !== 1'b0 || prdata[d] !== 32'h0 || pslverr[d] !== 1'b0 || regwr[d] !== '0) begin
        errors++;
        $display("FAIL reset_outs dut%0d got rdy=%b rd=%h err=%b wr=%h exp all 0",
                 d, pready[d], prdata[d], pslverr[d], regwr[d]);
      end
      check_regq(d);
    end
    rst_n[0] = 1'b1; rst_n[1] = 1'b1;

    for (int i = 0; i < NR; i++) xfer(0, 16'(i*4), 1'b0, 32'h0, 4'h0);
    xfer(0, 16'h0008, 1'b1, 32'hDEADBEEF, 4'hF);
    xfer(0, 16'h0008, 1'b0, 32'h0, 4'h0);
    xfer(0, 16'h0008, 1'b1, 32'h11223344, 4'h5);
    xfer(0, 16'h0008, 1'b0, 32'h0, 4'h0);
    xfer(0, 16'h000C, 1'b1, 32'hA5A5A5A5, 4'h0);
    xfer(0, 16'h0040, 1'b1, 32'hFFFFFFFF, 4'hF);
    xfer(0, 16'h0006, 1'b1, 32'hFFFFFFFF, 4'hF);
    xfer(0, 16'h0040, 1'b0, 32'h0, 4'h0);
    check_regq(0);
    xfer(1, 16'h0004, 1'b1, 32'hCAFEF00D, 4'hF);
    xfer(1, 16'h0004, 1'b0, 32'h0, 4'h0);
    xfer(1, 16'h0005, 1'b0, 32'h0, 4'h0);
    check_regq(1);
`ifdef APB_REG_LOCK_EN
    xfer(0, 16'h003C, 1'b1, 32'h1, 4'hF);
    xfer(0, 16'h0000, 1'b1, 32'h55, 4'hF);
    xfer(0, 16'h0000, 1'b0, 32'h0, 4'h0);
    xfer(0, 16'h003C, 1'b1, 32'h0, 4'hF);
    xfer(0, 16'h0000, 1'b1, 32'h55, 4'hF);
    xfer(0, 16'h0000, 1'b0, 32'h0, 4'h0);
    check_regq(0);
`endif

    for (int k = 0; k < 200; k++) begin
      int          d;
      logic [15:0] a;
      d = int'($urandom_range(0, 1));
      a = 16'($urandom_range(0, 19) * 4);
      if ($urandom_range(0, 9) == 0) a = a + 16'($urandom_range(1, 3));
      xfer(d, a, 1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)));
    end
    check_regq(0);
    check_regq(1);

    // Reset in the middle of a wait-stated write: the write must be lost.
    xfer(1, 16'h0004, 1'b1, 32'h0BADCAFE, 4'hF);
    @(posedge clk); #1;
    paddr[1] = 16'h0004; pwrite[1] = 1'b1; pwdata[1] = 32'h77777777; pstrb[1] = 4'hF;
    psel[1] = 1'b1; penable[1] = 1'b0;
    @(posedge clk); #1;
    penable[1] = 1'b1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    for (int i = 0; i < NR; i++) model[1][i] = RV3;
    checks++;
    if (pready[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_ready got %b exp 0", pready[1]);
    end
    check_regq(1);
    psel[1] = 1'b0; penable[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    xfer(1, 16'h0004, 1'b0, 32'h0, 4'h0);
    repeat (2) @(posedge clk);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      errors++;
      $display("FAIL pending got %0d/%0d responses left exp 0/0", q0.size(), q1.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_reg_slave.md
Name: apb_reg_slave

Overview:
Parametrised APB4 completer that exposes a bank of NUM_REGS read/write registers to fabric logic.
- Generalises the team's APB bus-functional slave into synthesisable RTL.
- Adds configurable wait states, byte strobes, address decode with PSLVERR, and per-register write pulses.
- Sits behind the APB converter as the reusable endpoint for control/status registers.

Parameters:
APB_ADDR_WIDTH, 16, PADDR width; must be at least clog2(NUM_REGS)+2.
APB_DATA_WIDTH, 32, PWDATA/PRDATA width; must be 8, 16 or 32.
NUM_REGS, 16, number of registers, 1..256; register i is at byte address i*(APB_DATA_WIDTH/8).
WAIT_STATES, 0, number of ACCESS cycles with PREADY low before completion, 0..15.
RESET_VALUE, 0, reset value loaded into every register.

Ports:
PCLK  in  1  APB clock; all state updates on the rising edge.
PRESETn  in  1  asynchronous active-low reset.
PADDR  in  APB_ADDR_WIDTH  byte address.
PWRITE  in  1  1 = write, 0 = read.
PWDATA  in  APB_DATA_WIDTH  write data.
PSTRB  in  APB_DATA_WIDTH/8  write byte strobes.
PSEL  in  1  slave select.
PENABLE  in  1  access phase.
PREADY  out  1  transfer completion.
PRDATA  out  APB_DATA_WIDTH  read data; valid only while PREADY=1.
PSLVERR  out  1  error response; valid only while PREADY=1.
reg_q  out  NUM_REGS*APB_DATA_WIDTH  flattened register contents; register i occupies bits [i*W +: W].
reg_wr  out  NUM_REGS  one-cycle pulse on the cycle after a register is successfully written.

Behaviour:
- Reset (PRESETn=0, asynchronous): all registers = RESET_VALUE, FSM = IDLE, wait counter = 0, reg_wr = 0. PREADY, PRDATA and PSLVERR read as 0.
- FSM states:
  - IDLE: PREADY=0. On PSEL=1 with PENABLE=0 (setup phase), go to ACCESS and clear the counter.
  - ACCESS: the counter increments each cycle while PSEL=1 and PENABLE=1 and the counter is below WAIT_STATES.
  - PREADY is combinational: PREADY = (state==ACCESS) && PSEL && PENABLE && (cnt==WAIT_STATES).
  - WAIT_STATES=0 gives a zero-wait transfer: PREADY=1 in the first access cycle.
  - On a rising edge with PREADY=1: commit the transfer, then go to IDLE.
  - Back-to-back transfers: the master re-asserts setup the next cycle; IDLE accepts it.
- Decode:
  - Index idx = PADDR >> clog2(W/8).
  - Error when idx >= NUM_REGS or the low address bits are non-zero (misaligned).
  - PSLVERR = PREADY && error.
- Write, committed at the PREADY edge, no error: for each byte b with PSTRB[b]=1, reg[idx] byte b <= PWDATA byte b. Bytes with PSTRB[b]=0 are unchanged.
  - reg_wr[idx] pulses for one cycle after the commit, even when PSTRB=0.
  - An erroring write modifies no register and produces no pulse.
- Read: PRDATA = reg[idx] when PREADY && !error && !PWRITE; otherwise 0. Reads have no side effects.
- Protocol violation: if PSEL drops in ACCESS before PREADY, abort to IDLE. No write, no pulse.
- PADDR, PWRITE, PWDATA and PSTRB are sampled only at the commit edge; the master holds them stable per APB.
- Reset asserted mid-transfer: immediate return to IDLE, registers reinitialised, the in-flight write is lost.

Optional Feature:
APB_REG_LOCK_EN
- Defined: register NUM_REGS-1 acts as a lock register.
  - While its bit0 = 1, writes to any other register are rejected: PSLVERR=1, no change, no pulse.
  - Writes to the lock register itself are always accepted.
  - Reads are unaffected.
- Undefined: no lock logic; register NUM_REGS-1 is an ordinary register.

Test Plan:
- Reset, then read all 16 registers (WAIT_STATES=0) -> each read completes in 2 cycles, PRDATA=0x00000000, PSLVERR=0.
- Write 0xDEADBEEF to 0x0008 with PSTRB=0xF, then read 0x0008 -> PRDATA=0xDEADBEEF, reg_wr[2] pulses exactly once, reg_q[95:64]=0xDEADBEEF.
- Write 0x11223344 to 0x0008 with PSTRB=0x5 over 0xDEADBEEF -> reads back 0xDE22BE44.
- WAIT_STATES=3, write to 0x0004 -> PREADY low for exactly 3 access cycles and high on the 4th; the total transfer is 5 cycles.
- Write to 0x0040 (idx 16) and to 0x0006 (misaligned) -> PSLVERR=1 with PREADY=1, no register changes, no reg_wr pulse; a read of 0x0040 returns PRDATA=0.
- With APB_REG_LOCK_EN: write 0x1 to 0x003C, then write 0x55 to 0x0000 -> PSLVERR=1 and register 0 unchanged. Write 0x0 to 0x003C, then repeat -> accepted, register 0 = 0x55. Also pulse PRESETn low during a WAIT_STATES=3 write -> PREADY=0 at once and the target register = RESET_VALUE.
